// File: rtl/sensor_link_scheduler.sv
// sensor_link_scheduler
//   Arbitrates eight 8-bit sensor channels (S1..S8) round-robin onto a shared
//   11-bit packet link, pacote = {id[2:0], data[7:0]}. Holds each packet until
//   the receiver accepts it, resending on request up to MAX_RETRIES times.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   req[7:0]            bit i: sensor S(i+1) has data (level, held until grant)
//   S1..S8[7:0]         sensor data, id 0 = S1 .. id 7 = S8
//   pacote_ok           receiver accepted current packet (pulse)
//   solicitar_reenvio   receiver asks for retransmission (pulse)
//   pacote[10:0]        {id, data}, stable from SEND until leaving WAIT
//   pacote_valido       1-cycle strobe while the packet is being sent
//   grant[7:0]          one-hot pulse: sensor request consumed
//   falha               pulse: packet dropped after retries exhausted
//   ocupado             high whenever not IDLE
//
// Optional feature (macro ACK_TIMEOUT_EN): a WAIT-cycle counter that treats
// TIMEOUT silent WAIT cycles as an implicit solicitar_reenvio.

`timescale 1ns/1ps

module sensor_link_scheduler #(
    parameter int unsigned MAX_RETRIES = 3,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  req,
    input  logic [7:0]  S1,
    input  logic [7:0]  S2,
    input  logic [7:0]  S3,
    input  logic [7:0]  S4,
    input  logic [7:0]  S5,
    input  logic [7:0]  S6,
    input  logic [7:0]  S7,
    input  logic [7:0]  S8,
    input  logic        pacote_ok,
    input  logic        solicitar_reenvio,
    output logic [10:0] pacote,
    output logic        pacote_valido,
    output logic [7:0]  grant,
    output logic        falha,
    output logic        ocupado
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [3:0]  retry_cnt;
    logic [2:0]  ptr;
    logic [2:0]  sel_id;
    logic        sel_found;
    logic [2:0]  idx;
    logic [7:0]  s_data [8];

    logic        resend;
    logic        retry_left;
    logic        do_retry;
    logic        give_up;
    logic        accept;

    always_comb begin
        s_data[0] = S1;
        s_data[1] = S2;
        s_data[2] = S3;
        s_data[3] = S4;
        s_data[4] = S5;
        s_data[5] = S6;
        s_data[6] = S7;
        s_data[7] = S8;
    end

    // Round-robin search: start just above the last served id and wrap.
    always_comb begin
        sel_id    = ptr;
        sel_found = 1'b0;
        idx       = '0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = 3'(ptr + 3'(i));
            if (!sel_found && req[idx]) begin
                sel_id    = idx;
                sel_found = 1'b1;
            end
        end
    end

`ifdef ACK_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timed_out;

    // wait_cnt counts WAIT cycles already completed, so the edge ending the
    // TIMEOUT-th silent WAIT cycle sees wait_cnt == TIMEOUT-1.
    always_comb begin
        timed_out = (state == WAIT) && (wait_cnt == 8'(TIMEOUT - 1));
        resend    = solicitar_reenvio || (timed_out && !pacote_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == SEND) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    always_comb begin
        resend = solicitar_reenvio;
    end
`endif

    // solicitar_reenvio (or timeout) takes priority over pacote_ok.
    always_comb begin
        retry_left = (retry_cnt < 4'(MAX_RETRIES));
        do_retry   = (state == WAIT) && resend && retry_left;
        give_up    = (state == WAIT) && resend && !retry_left;
        accept     = (state == WAIT) && !resend && pacote_ok;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                next_state = WAIT;
            end
            WAIT: begin
                if (do_retry) begin
                    next_state = SEND;
                end else if (give_up || accept) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        pacote_valido = (state == SEND);
        ocupado       = (state != IDLE);
    end

    // Packet, retry and arbitration datapath; grant/falha are registered so
    // they appear in the cycle ocupado falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            pacote    <= '0;
            retry_cnt <= '0;
            ptr       <= 3'd7;
            grant     <= '0;
            falha     <= 1'b0;
        end else begin
            grant <= '0;
            falha <= 1'b0;
            if (state == IDLE && sel_found) begin
                pacote    <= {sel_id, s_data[sel_id]};
                retry_cnt <= '0;
            end
            if (do_retry) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
            if (give_up || accept) begin
                grant <= 8'b1 << pacote[10:8];
                ptr   <= pacote[10:8];
                falha <= give_up;
            end
        end
    end

endmodule
